cpri_dr_rx_unpack: RTL and testbench

- Far-end receiver for the beam-reduced CPRI stream that the PUSCH DR chain transmits on each of its two tx lanes.
- Consumes one lane of 64-bit CPRI words, hunts the packet sync word and decodes the 6-word header (ids, per-beam FFT AGC, per-beam power).
- De-serialises the payload into one 8-beam IQ vector per RE, with sop/eop framing.
- Sits on the BBU/loopback side. It is also the checker model used by verification.

---
 rtl/cpri_dr_rx_unpack.sv | 201 ++++++++++++++++++++
 tb/tb_cpri_dr_rx_unpack.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpri_dr_rx_unpack.sv
// CPRI DR lane receiver: hunts the sync word, decodes the 6-word header and
// unpacks the payload into one BEAM_LN-beam IQ vector per RE.
module cpri_dr_rx_unpack #(
   parameter int unsigned BEAM_LN = 8,
   parameter int unsigned MAX_RE  = 192,
   parameter logic [15:0] SYNC    = 16'hC5A3
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic [63:0]             i_rx_data,
   input  logic                    i_rx_vld,
   output logic [3:0]              o_pkg_type,
   output logic                    o_cell_idx,
   output logic [6:0]              o_slot_idx,
   output logic [3:0]              o_symb_idx,
   output logic [3:0]              o_rbg_idx,
   output logic [1:0]              o_aiu_idx,
   output logic [9:0]              o_re_num,
   output logic [BEAM_LN*8-1:0]    o_fft_agc,
   output logic [BEAM_LN*32-1:0]   o_beam_pwr,
   output logic                    o_hdr_vld,
   output logic [BEAM_LN*32-1:0]   o_iq_data,
   output logic                    o_iq_vld,
   output logic                    o_sop,
   output logic                    o_eop,
   output logic [9:0]              o_re_idx,
   output logic                    o_hdr_err,
   output logic [15:0]             o_drop_cnt
);

   localparam int unsigned WPR = BEAM_LN / 2;
   localparam int unsigned HCW = $clog2(WPR + 1);
   localparam int unsigned WCW = (WPR > 1) ? $clog2(WPR) : 1;
   localparam int unsigned AW  = BEAM_LN * 8;
   localparam int unsigned PW  = BEAM_LN * 32;
   localparam int unsigned HW  = 32;

   typedef enum logic [1:0] {ST_HUNT, ST_HDR, ST_PLD} state_t;

   state_t           state_q, state_d;
   logic [HCW-1:0]   hdr_cnt_q, hdr_cnt_d;
   logic [WCW-1:0]   w_q, w_d;
   logic [9:0]       r_q, r_d;
   logic [HW-1:0]    sh_h0_q, sh_h0_d;
   logic [AW-1:0]    sh_agc_q, sh_agc_d;
   logic [PW-1:0]    sh_pwr_q, sh_pwr_d;
   logic [PW-1:0]    iq_acc_q, iq_acc_d;
   logic [HW-1:0]    hdr_q, hdr_d;
   logic [AW-1:0]    fft_agc_q, fft_agc_d;
   logic [PW-1:0]    beam_pwr_q, beam_pwr_d;
   logic             hdr_vld_q, hdr_vld_d;
   logic [PW-1:0]    iq_data_q, iq_data_d;
   logic             iq_vld_q, iq_vld_d;
   logic             sop_q, sop_d;
   logic             eop_q, eop_d;
   logic [9:0]       re_idx_q, re_idx_d;
   logic             hdr_err_q, hdr_err_d;
   logic [15:0]      drop_cnt_q, drop_cnt_d;

   // Next-state, capture and output pulses; everything advances on valid words only.
   always_comb begin
      state_d    = state_q;
      hdr_cnt_d  = hdr_cnt_q;
      w_d        = w_q;
      r_d        = r_q;
      sh_h0_d    = sh_h0_q;
      sh_agc_d   = sh_agc_q;
      sh_pwr_d   = sh_pwr_q;
      iq_acc_d   = iq_acc_q;
      hdr_d      = hdr_q;
      fft_agc_d  = fft_agc_q;
      beam_pwr_d = beam_pwr_q;
      iq_data_d  = iq_data_q;
      re_idx_d   = re_idx_q;
      drop_cnt_d = drop_cnt_q;
      hdr_vld_d  = 1'b0;
      iq_vld_d   = 1'b0;
      sop_d      = 1'b0;
      eop_d      = 1'b0;
      hdr_err_d  = 1'b0;

      if (i_rx_vld) begin
         unique case (state_q)
            ST_HUNT: begin
               if (i_rx_data[63:48] == SYNC) begin
                  sh_h0_d   = i_rx_data[47:16];
                  hdr_cnt_d = '0;
                  state_d   = ST_HDR;
               end else if (drop_cnt_q != 16'hFFFF) begin
                  drop_cnt_d = drop_cnt_q + 16'd1;
               end
            end
            ST_HDR: begin
               if (hdr_cnt_q == '0) begin
                  sh_agc_d = AW'(i_rx_data);
               end
               for (int k = 0; k < WPR; k++) begin
                  if (hdr_cnt_q == HCW'(k + 1)) sh_pwr_d[64*k +: 64] = i_rx_data;
               end
               hdr_cnt_d = hdr_cnt_q + HCW'(1);
               // Last power word: commit or reject the whole header in one step.
               if (hdr_cnt_q == HCW'(WPR)) begin
                  hdr_cnt_d = '0;
                  w_d       = '0;
                  r_d       = '0;
                  if (sh_h0_q[9:0] > 10'(MAX_RE)) begin
                     hdr_err_d = 1'b1;
                     state_d   = ST_HUNT;
                  end else begin
                     hdr_d      = sh_h0_q;
                     fft_agc_d  = sh_agc_d;
                     beam_pwr_d = sh_pwr_d;
                     hdr_vld_d  = 1'b1;
                     state_d    = (sh_h0_q[9:0] == 10'd0) ? ST_HUNT : ST_PLD;
                  end
               end
            end
            ST_PLD: begin
               for (int k = 0; k < WPR; k++) begin
                  if (w_q == WCW'(k)) iq_acc_d[64*k +: 64] = i_rx_data;
               end
               w_d = w_q + WCW'(1);
               if (w_q == WCW'(WPR - 1)) begin
                  w_d       = '0;
                  iq_data_d = iq_acc_d;
                  iq_vld_d  = 1'b1;
                  re_idx_d  = r_q;
                  sop_d     = (r_q == 10'd0);
                  eop_d     = (r_q == hdr_q[9:0] - 10'd1);
                  r_d       = r_q + 10'd1;
                  if (r_q == hdr_q[9:0] - 10'd1) state_d = ST_HUNT;
               end
            end
            default: state_d = ST_HUNT;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q    <= ST_HUNT;
         hdr_cnt_q  <= '0;
         w_q        <= '0;
         r_q        <= '0;
         sh_h0_q    <= '0;
         sh_agc_q   <= '0;
         sh_pwr_q   <= '0;
         iq_acc_q   <= '0;
         hdr_q      <= '0;
         fft_agc_q  <= '0;
         beam_pwr_q <= '0;
         hdr_vld_q  <= 1'b0;
         iq_data_q  <= '0;
         iq_vld_q   <= 1'b0;
         sop_q      <= 1'b0;
         eop_q      <= 1'b0;
         re_idx_q   <= '0;
         hdr_err_q  <= 1'b0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         hdr_cnt_q  <= hdr_cnt_d;
         w_q        <= w_d;
         r_q        <= r_d;
         sh_h0_q    <= sh_h0_d;
         sh_agc_q   <= sh_agc_d;
         sh_pwr_q   <= sh_pwr_d;
         iq_acc_q   <= iq_acc_d;
         hdr_q      <= hdr_d;
         fft_agc_q  <= fft_agc_d;
         beam_pwr_q <= beam_pwr_d;
         hdr_vld_q  <= hdr_vld_d;
         iq_data_q  <= iq_data_d;
         iq_vld_q   <= iq_vld_d;
         sop_q      <= sop_d;
         eop_q      <= eop_d;
         re_idx_q   <= re_idx_d;
         hdr_err_q  <= hdr_err_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign o_pkg_type = hdr_q[31:28];
   assign o_cell_idx = hdr_q[27];
   assign o_slot_idx = hdr_q[26:20];
   assign o_symb_idx = hdr_q[19:16];
   assign o_rbg_idx  = hdr_q[15:12];
   assign o_aiu_idx  = hdr_q[11:10];
   assign o_re_num   = hdr_q[9:0];
   assign o_fft_agc  = fft_agc_q;
   assign o_beam_pwr = beam_pwr_q;
   assign o_hdr_vld  = hdr_vld_q;
   assign o_iq_data  = iq_data_q;
   assign o_iq_vld   = iq_vld_q;
   assign o_sop      = sop_q;
   assign o_eop      = eop_q;
   assign o_re_idx   = re_idx_q;
   assign o_hdr_err  = hdr_err_q;
   assign o_drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_cpri_dr_rx_unpack.sv
// Bench for cpri_dr_rx_unpack: packet-level model predicts the ordered stream
// of header / error / RE output events and the drop counter.
module tb_cpri_dr_rx_unpack;

   logic          i_clk = 1'b0;
   logic          i_reset;
   logic [63:0]   i_rx_data;
   logic          i_rx_vld;
   logic [3:0]    o_pkg_type;
   logic          o_cell_idx;
   logic [6:0]    o_slot_idx;
   logic [3:0]    o_symb_idx;
   logic [3:0]    o_rbg_idx;
   logic [1:0]    o_aiu_idx;
   logic [9:0]    o_re_num;
   logic [63:0]   o_fft_agc;
   logic [255:0]  o_beam_pwr;
   logic          o_hdr_vld;
   logic [255:0]  o_iq_data;
   logic          o_iq_vld;
   logic          o_sop;
   logic          o_eop;
   logic [9:0]    o_re_idx;
   logic          o_hdr_err;
   logic [15:0]   o_drop_cnt;

   cpri_dr_rx_unpack dut (
      .i_clk(i_clk), .i_reset(i_reset), .i_rx_data(i_rx_data), .i_rx_vld(i_rx_vld),
      .o_pkg_type(o_pkg_type), .o_cell_idx(o_cell_idx), .o_slot_idx(o_slot_idx),
      .o_symb_idx(o_symb_idx), .o_rbg_idx(o_rbg_idx), .o_aiu_idx(o_aiu_idx),
      .o_re_num(o_re_num), .o_fft_agc(o_fft_agc), .o_beam_pwr(o_beam_pwr),
      .o_hdr_vld(o_hdr_vld), .o_iq_data(o_iq_data), .o_iq_vld(o_iq_vld),
      .o_sop(o_sop), .o_eop(o_eop), .o_re_idx(o_re_idx), .o_hdr_err(o_hdr_err),
      .o_drop_cnt(o_drop_cnt)
   );

   always #5 i_clk = ~i_clk;

   typedef struct {
      int            kind;   // 1 header, 2 header error, 3 RE
      logic [31:0]   h0;
      logic [63:0]   agc;
      logic [255:0]  pwr;
      logic [255:0]  iq;
      logic [9:0]    idx;
      logic          sop;
      logic          eop;
   } ev_t;

   ev_t           exp_q[$];
   int            n_tests = 0;
   int            n_fail  = 0;
   int            exp_drop = 0;
   logic [31:0]   cur_h;
   logic [63:0]   cur_agc;
   logic [255:0]  cur_pwr;

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] hdr_obs();
      return {o_pkg_type, o_cell_idx, o_slot_idx, o_symb_idx, o_rbg_idx, o_aiu_idx, o_re_num};
   endfunction

   // Output monitor: every pulse must match the next predicted event, in order.
   always @(negedge i_clk) begin
      if (!i_reset && (o_hdr_vld || o_hdr_err || o_iq_vld)) begin
         int   kind;
         ev_t  e;
         kind = o_iq_vld ? 3 : (o_hdr_err ? 2 : 1);
         chk("pulse_excl", 256'(int'(o_hdr_vld) + int'(o_hdr_err) + int'(o_iq_vld)), 256'd1);
         if (exp_q.size() == 0) begin
            chk("unexpected_pulse", 256'(kind), 256'd0);
         end else begin
            e = exp_q.pop_front();
            chk("ev_kind", 256'(kind), 256'(e.kind));
            if (e.kind == 3) begin
               chk("iq_data", o_iq_data, e.iq);
               chk("re_idx", 256'(o_re_idx), 256'(e.idx));
               chk("sop_eop", 256'({o_sop, o_eop}), 256'({e.sop, e.eop}));
            end else begin
               chk("hdr_fields", 256'(hdr_obs()), 256'(e.h0));
               chk("hdr_agc", 256'(o_fft_agc), 256'(e.agc));
               chk("hdr_pwr", o_beam_pwr, e.pwr);
            end
         end
      end
   end

   task automatic send_word(input logic [63:0] w, input bit gaps);
      if (gaps) begin
         repeat ($urandom_range(0, 2)) begin
            i_rx_vld = 1'b0;
            i_rx_data = {$urandom, $urandom};
            @(posedge i_clk); #1;
         end
      end
      i_rx_data = w;
      i_rx_vld  = 1'b1;
      @(posedge i_clk); #1;
      i_rx_vld  = 1'b0;
   endtask

   function automatic logic [63:0] junk();
      logic [63:0] w;
      w = {$urandom, $urandom};
      if (w[63:48] == 16'hC5A3) w[48] = ~w[48];
      return w;
   endfunction

   function automatic logic [255:0] gen_re(input int mode, input int r);
      logic [255:0] v;
      for (int b = 0; b < 8; b++) begin
         if (mode == 0) v[32*b +: 32] = {16'(r), 16'(b)};
         else           v[32*b +: 32] = $urandom;
      end
      return v;
   endfunction

   // Build the predicted event list for one packet, then transmit it.
   task automatic send_pkt(input logic [31:0] hf, input logic [63:0] agc, input logic [255:0] pwr,
                           input int mode, input bit gaps, input int stop_re);
      int            re_num;
      int            n_send;
      logic [255:0]  pl[$];
      ev_t           e;
      re_num = int'(hf[9:0]);
      e = '{kind: 1, h0: hf, agc: agc, pwr: pwr, iq: '0, idx: '0, sop: 1'b0, eop: 1'b0};
      if (re_num > 192) begin
         e.kind = 2; e.h0 = cur_h; e.agc = cur_agc; e.pwr = cur_pwr;
         exp_q.push_back(e);
         n_send = 0;
      end else begin
         exp_q.push_back(e);
         cur_h = hf; cur_agc = agc; cur_pwr = pwr;
         n_send = (stop_re < 0) ? re_num : stop_re;
      end
      for (int r = 0; r < n_send; r++) begin
         logic [255:0] v;
         v = gen_re(mode, r);
         if (mode == 2 && r == 0) v[127:64] = 64'hC5A3_0000_1234_5678;
         pl.push_back(v);
         e = '{kind: 3, h0: '0, agc: '0, pwr: '0, iq: v, idx: 10'(r),
               sop: (r == 0), eop: (r == re_num - 1)};
         exp_q.push_back(e);
      end
      send_word({16'hC5A3, hf, 16'($urandom)}, gaps);
      send_word(agc, gaps);
      for (int k = 0; k < 4; k++) send_word(pwr[64*k +: 64], gaps);
      for (int r = 0; r < n_send; r++)
         for (int k = 0; k < 4; k++) send_word(pl[r][64*k +: 64], gaps);
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      repeat (2) @(negedge i_clk);
      while (exp_q.size() != 0 && n < 50) begin
         @(negedge i_clk);
         n++;
      end
      chk(tag, 256'(exp_q.size()), 256'd0);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_hdr"}, 256'(hdr_obs()), 256'd0);
      chk({tag, "_agc"}, 256'(o_fft_agc), 256'd0);
      chk({tag, "_pwr"}, o_beam_pwr, 256'd0);
      chk({tag, "_iq"}, o_iq_data, 256'd0);
      chk({tag, "_misc"}, 256'({o_hdr_vld, o_iq_vld, o_sop, o_eop, o_re_idx, o_hdr_err, o_drop_cnt}), 256'd0);
   endtask

   function automatic logic [31:0] rand_hf(input int re_num);
      logic [31:0] h;
      h = $urandom;
      h[9:0] = 10'(re_num);
      return h;
   endfunction

   function automatic logic [255:0] rand_pwr();
      logic [255:0] p;
      for (int b = 0; b < 8; b++) p[32*b +: 32] = $urandom;
      return p;
   endfunction

   initial begin
      logic [31:0]   hf_a;
      logic [63:0]   agc_a;
      logic [255:0]  pwr_a;

      i_reset = 1'b1; i_rx_vld = 1'b0; i_rx_data = '0;
      cur_h = '0; cur_agc = '0; cur_pwr = '0;
      @(posedge i_clk); #1;
      chk_zero("reset");
      repeat (2) @(posedge i_clk);
      #1 i_reset = 1'b0;

      hf_a = {4'd2, 1'b1, 7'd37, 4'd9, 4'd5, 2'd3, 10'd192};
      for (int b = 0; b < 8; b++) begin
         agc_a[8*b +: 8]  = 8'(8'h10 + b);
         pwr_a[32*b +: 32] = 32'(b);
      end

      // Junk then two back-to-back packets.
      for (int i = 0; i < 3; i++) send_word(junk(), 1'b0);
      exp_drop += 3;
      send_pkt(hf_a, agc_a, pwr_a, 0, 1'b0, -1);
      send_pkt(rand_hf($urandom_range(1, 40)), {$urandom, $urandom}, rand_pwr(), 1, 1'b0, -1);
      drain("drain_b2b");
      chk("drop_cnt_3", 256'(o_drop_cnt), 256'(exp_drop));

      // Same packet with valid gaps.
      send_pkt(hf_a, agc_a, pwr_a, 0, 1'b1, -1);
      drain("drain_gaps");

      // Empty packet, then re_num=1 with a sync-looking payload word, then illegal re_num.
      send_pkt(rand_hf(0), {$urandom, $urandom}, rand_pwr(), 1, 1'b0, -1);
      send_pkt(rand_hf(1), {$urandom, $urandom}, rand_pwr(), 2, 1'b0, -1);
      drain("drain_re1");
      send_pkt(rand_hf(200), {$urandom, $urandom}, rand_pwr(), 1, 1'b0, -1);
      drain("drain_err");
      chk("hdr_hold_after_err", 256'(hdr_obs()), 256'(cur_h));
      send_pkt(rand_hf($urandom_range(2, 40)), {$urandom, $urandom}, rand_pwr(), 1, 1'b1, -1);
      drain("drain_recover");
      chk("drop_cnt_pkts", 256'(o_drop_cnt), 256'(exp_drop));

      // Asynchronous reset mid-packet after RE 49.
      send_pkt(hf_a, agc_a, pwr_a, 0, 1'b0, 50);
      @(negedge i_clk);
      #2 i_reset = 1'b1;
      #1 chk_zero("mid_reset");
      chk("mid_reset_q", 256'(exp_q.size()), 256'd0);
      exp_q.delete();
      cur_h = '0; cur_agc = '0; cur_pwr = '0; exp_drop = 0;
      repeat (2) @(posedge i_clk);
      #1 i_reset = 1'b0;
      send_pkt(rand_hf($urandom_range(1, 40)), {$urandom, $urandom}, rand_pwr(), 1, 1'b0, -1);
      drain("drain_fresh");

      // Drop counter saturation.
      for (int i = 0; i < 70000; i++) send_word(junk(), 1'b0);
      exp_drop = (exp_drop + 70000 > 65535) ? 65535 : exp_drop + 70000;
      @(negedge i_clk);
      chk("drop_sat", 256'(o_drop_cnt), 256'(exp_drop));
      send_word(junk(), 1'b0);
      @(negedge i_clk);
      chk("drop_no_wrap", 256'(o_drop_cnt), 256'(exp_drop));
      chk("final_q", 256'(exp_q.size()), 256'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
